// File: rtl/riscv_core_vector_chunk_seq_if.sv
// rtl/riscv_core_vector_chunk_seq_if.sv - request, regfile and execute signals of the vector chunk sequencer
interface riscv_core_vector_chunk_seq_if;
  logic       req_val;
  logic       req_rdy;
  logic [4:0] req_vs0;
  logic [4:0] req_vs1;
  logic [4:0] req_vd;
  logic [2:0] req_inter;
  logic [6:0] req_vlen;
  logic       stall;
  logic [4:0] v_raddr0;
  logic [4:0] v_raddr1;
  logic       v_rinter0;
  logic       v_rinter1;
  logic [5:0] v_ridx0;
  logic [5:0] v_ridx1;
  logic       exe_val;
  logic [1:0] exe_lanes;
  logic       v_wen_p;
  logic [4:0] v_waddr_p;
  logic       v_winter;
  logic [5:0] v_widx_p;
  logic [1:0] v_lanes;
  logic       done;

  modport master (
    output req_val, req_vs0, req_vs1, req_vd, req_inter, req_vlen, stall,
    input  req_rdy, v_raddr0, v_raddr1, v_rinter0, v_rinter1, v_ridx0, v_ridx1,
           exe_val, exe_lanes, v_wen_p, v_waddr_p, v_winter, v_widx_p, v_lanes, done
  );

  modport slave (
    input  req_val, req_vs0, req_vs1, req_vd, req_inter, req_vlen, stall,
    output req_rdy, v_raddr0, v_raddr1, v_rinter0, v_rinter1, v_ridx0, v_ridx1,
           exe_val, exe_lanes, v_wen_p, v_waddr_p, v_winter, v_widx_p, v_lanes, done
  );
endinterface

// File: rtl/riscv_core_vector_chunk_seq.sv
// rtl/riscv_core_vector_chunk_seq.sv - walks one vector op in 4-lane chunks with delayed writeback
module riscv_core_vector_chunk_seq #(
  parameter int EXE_LAT = 2
) (
  input logic                          clk,
  input logic                          reset,
  riscv_core_vector_chunk_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ZERO} state_t;

  state_t     state, state_nxt;
  logic [3:0] chunk;
  logic [3:0] last_chunk;
  logic [1:0] last_lanes;
  logic [4:0] raddr0, raddr1, waddr;
  logic       rinter0, rinter1, winter;

  // Writeback delay line; slot EXE_LAT-1 is the write being presented.
  logic       dl_val   [EXE_LAT];
  logic [3:0] dl_chunk [EXE_LAT];
  logic [1:0] dl_lanes [EXE_LAT];
  logic       dl_last  [EXE_LAT];

  logic       accept;
  logic       is_last;
  logic [1:0] cur_lanes;
  logic       rd_fire;
  logic       wr_fire;
  logic [5:0] vlen_m1;

  // Lengths of 64 and above all collapse to 64 elements (last index 63).
  assign vlen_m1   = (bus.req_vlen >= 7'd64) ? 6'd63 : (bus.req_vlen[5:0] - 6'd1);
  assign accept    = (state == IDLE) && bus.req_val;
  assign is_last   = (chunk == last_chunk);
  assign cur_lanes = is_last ? last_lanes : 2'd3;
  assign rd_fire   = (state == ISSUE) && !bus.stall;
  assign wr_fire   = dl_val[EXE_LAT-1] && !bus.stall;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = (bus.req_vlen == 7'd0) ? ZERO : ISSUE;
      ISSUE: if (rd_fire && is_last) state_nxt = DRAIN;
      DRAIN: if (wr_fire && dl_last[EXE_LAT-1]) state_nxt = IDLE;
      ZERO:  if (!bus.stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      chunk      <= 4'd0;
      last_chunk <= 4'd0;
      last_lanes <= 2'd0;
      raddr0     <= 5'd0;
      raddr1     <= 5'd0;
      waddr      <= 5'd0;
      rinter0    <= 1'b0;
      rinter1    <= 1'b0;
      winter     <= 1'b0;
      for (int i = 0; i < EXE_LAT; i++) begin
        dl_val[i]   <= 1'b0;
        dl_chunk[i] <= 4'd0;
        dl_lanes[i] <= 2'd0;
        dl_last[i]  <= 1'b0;
      end
    end else begin
      state <= state_nxt;
      if (accept) begin
        chunk      <= 4'd0;
        last_chunk <= vlen_m1[5:2];
        last_lanes <= vlen_m1[1:0];
        raddr0     <= bus.req_vs0;
        raddr1     <= bus.req_vs1;
        waddr      <= bus.req_vd;
        rinter0    <= bus.req_inter[0];
        rinter1    <= bus.req_inter[1];
        winter     <= bus.req_inter[2];
      end else if (rd_fire && !is_last) begin
        chunk <= chunk + 4'd1;
      end
      // Stall freezes the line so pending writes are re-presented afterwards.
      if (!bus.stall) begin
        for (int i = EXE_LAT - 1; i > 0; i--) begin
          dl_val[i]   <= dl_val[i-1];
          dl_chunk[i] <= dl_chunk[i-1];
          dl_lanes[i] <= dl_lanes[i-1];
          dl_last[i]  <= dl_last[i-1];
        end
        dl_val[0]   <= rd_fire;
        dl_chunk[0] <= chunk;
        dl_lanes[0] <= cur_lanes;
        dl_last[0]  <= is_last;
      end
    end
  end

  assign bus.req_rdy   = (state == IDLE);
  assign bus.v_raddr0  = raddr0;
  assign bus.v_raddr1  = raddr1;
  assign bus.v_rinter0 = rinter0;
  assign bus.v_rinter1 = rinter1;
  assign bus.v_ridx0   = {chunk, 2'b00};
  assign bus.v_ridx1   = {chunk, 2'b00};
  assign bus.exe_val   = rd_fire;
  assign bus.exe_lanes = cur_lanes;
  assign bus.v_wen_p   = wr_fire;
  assign bus.v_waddr_p = waddr;
  assign bus.v_winter  = winter;
  assign bus.v_widx_p  = {dl_chunk[EXE_LAT-1], 2'b00};
  assign bus.v_lanes   = dl_lanes[EXE_LAT-1];
  assign bus.done      = (wr_fire && dl_last[EXE_LAT-1]) || ((state == ZERO) && !bus.stall);

endmodule

// File: tb/tb_riscv_core_vector_chunk_seq.sv
// tb/tb_riscv_core_vector_chunk_seq.sv - scoreboard bench for the vector chunk sequencer
module tb_riscv_core_vector_chunk_seq;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  riscv_core_vector_chunk_seq_if bus();

  riscv_core_vector_chunk_seq #(.EXE_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int idx;
    int lanes;
    int a;
    int b;
    int ia;
    int ib;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read, write or done.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (bus.exe_val) begin
        if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          e = rd_q.pop_front();
          chk("read_cycle", cyc, e.cyc);
          chk("ridx0", int'(bus.v_ridx0), e.idx);
          chk("ridx1", int'(bus.v_ridx1), e.idx);
          chk("exe_lanes", int'(bus.exe_lanes), e.lanes);
          chk("raddr0", int'(bus.v_raddr0), e.a);
          chk("raddr1", int'(bus.v_raddr1), e.b);
          chk("rinter0", int'(bus.v_rinter0), e.ia);
          chk("rinter1", int'(bus.v_rinter1), e.ib);
        end
      end
      if (bus.v_wen_p) begin
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("widx", int'(bus.v_widx_p), e.idx);
          chk("v_lanes", int'(bus.v_lanes), e.lanes);
          chk("waddr", int'(bus.v_waddr_p), e.a);
          chk("winter", int'(bus.v_winter), e.ia);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  function automatic int sh(input int t, input int a, input int s, input int len);
    return (len > 0 && t >= a + s) ? t + len : t;
  endfunction

  // Called #1 into an idle cycle. n / ll are the hand-computed chunk count and last lanes-1.
  task automatic do_op(input int vs0, input int vs1, input int vd, input int inter,
                       input int vlen, input int n, input int ll,
                       input int st_at, input int st_len, input int rst_at, input bit hold);
    int  a, td, end_cyc, iter;
    ev_t e;
    chk("req_rdy_idle", int'(bus.req_rdy), 1);
    bus.req_vs0   = 5'(vs0);
    bus.req_vs1   = 5'(vs1);
    bus.req_vd    = 5'(vd);
    bus.req_inter = 3'(inter);
    bus.req_vlen  = 7'(vlen);
    bus.req_val   = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    if (hold) begin
      bus.req_vs0   = ~5'(vs0);
      bus.req_vs1   = ~5'(vs1);
      bus.req_vd    = ~5'(vd);
      bus.req_inter = ~3'(inter);
      bus.req_vlen  = 7'd3;
    end else begin
      bus.req_val = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      e.idx   = 4 * k;
      e.lanes = (k == n - 1) ? ll : 3;
      e.cyc = sh(a + k, a, st_at, st_len);
      e.a = vs0; e.b = vs1; e.ia = inter & 1; e.ib = (inter >> 1) & 1;
      if (rst_at == 0 || e.cyc < a + rst_at) rd_q.push_back(e);
      e.cyc = sh(a + k + LAT, a, st_at, st_len);
      e.a = vd; e.b = 0; e.ia = (inter >> 2) & 1; e.ib = 0;
      if (rst_at == 0 || e.cyc < a + rst_at) wr_q.push_back(e);
    end
    td = (n == 0) ? sh(a, a, st_at, st_len) : sh(a + n - 1 + LAT, a, st_at, st_len);
    if (rst_at == 0) done_q.push_back(td);
    end_cyc = (rst_at == 0) ? td : a + rst_at;
    iter = 0;
    while (cyc <= end_cyc && iter < 300) begin
      iter++;
      bus.stall = (st_len > 0 && cyc >= a + st_at && cyc < a + st_at + st_len);
      if (rst_at > 0 && cyc == a + rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_req_rdy", int'(bus.req_rdy), 1);
        chk("rst_exe_val", int'(bus.exe_val), 0);
        chk("rst_ridx0", int'(bus.v_ridx0), 0);
        chk("rst_waddr", int'(bus.v_waddr_p), 0);
        chk("rst_raddr0", int'(bus.v_raddr0), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        break;
      end
      if (cyc == end_cyc) begin
        chk("req_rdy_busy_last", int'(bus.req_rdy), 0);
        if (hold) bus.req_val = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (iter >= 300) chk("op_timeout", 1, 0);
    bus.stall   = 1'b0;
    bus.req_val = 1'b0;
    chk("req_rdy_after", int'(bus.req_rdy), 1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_val   = 1'b0;
    bus.req_vs0   = 5'd0;
    bus.req_vs1   = 5'd0;
    bus.req_vd    = 5'd0;
    bus.req_inter = 3'd0;
    bus.req_vlen  = 7'd0;
    bus.stall     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_rdy", int'(bus.req_rdy), 1);
    chk("reset_exe_val", int'(bus.exe_val), 0);
    chk("reset_wen", int'(bus.v_wen_p), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_widx", int'(bus.v_widx_p), 0);
    chk("reset_lanes", int'(bus.v_lanes), 0);
    chk("reset_exe_lanes", int'(bus.exe_lanes), 0);
    chk("reset_winter", int'(bus.v_winter), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    //     vs0 vs1 vd inter vlen  N  ll  st_at st_len rst hold
    do_op(1,  2,  3,  0,     8,   2, 3,  0,    0,     0,  0);
    do_op(5,  6,  5,  0,     6,   2, 1,  0,    0,     0,  0);
    do_op(7,  8,  9,  2,     64,  16, 3, 0,    0,     0,  0);
    do_op(10, 11, 12, 0,     100, 16, 3, 0,    0,     0,  0);
    do_op(13, 14, 15, 0,     0,   0, 0,  0,    0,     0,  0);
    do_op(16, 17, 18, 0,     12,  3, 3,  1,    2,     0,  0);
    do_op(19, 20, 21, 0,     8,   2, 3,  3,    1,     0,  0);
    do_op(22, 23, 24, 0,     16,  4, 3,  0,    0,     1,  0);
    do_op(25, 26, 27, 5,     5,   2, 0,  0,    0,     0,  1);
    do_op(28, 29, 30, 0,     1,   1, 0,  0,    0,     0,  0);
    do_op(31, 0,  4,  7,     65,  16, 3, 0,    0,     0,  0);

    repeat (6) @(posedge clk);
    #1;
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
